// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller writeback sequencer.
package mc_pkg;
  localparam int unsigned NUM_CORES   = 4;
  localparam int unsigned NUM_ROWS    = 4;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam logic [3:0]  ROW_BASE    = 4'b1000;

  typedef enum logic [1:0] {
    COLLECT,
    WRITE,
    DONE
  } wb_state_t;
endpackage

// File: rtl/wb_ack_timer.sv
// Per-row MEM_ACK wait timer: counts cycles spent in the current row without an ack.
module wb_ack_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + 4'd1;
  end

  // Count starts at 0 on a row's first cycle, so this flags its LIMIT-th cycle.
  assign expired = (count == 4'(LIMIT - 1));
endmodule

// File: rtl/mem_writeback_ctrl.sv
// Gathers per-core store-complete flags, then drains the staging buffer row by row
// under a MEM_ACK handshake with per-row timeout.
module mem_writeback_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYC = mc_pkg::ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MEMWR_1,
  input  logic       MEMWR_2,
  input  logic       MEMWR_3,
  input  logic       MEMWR_4,
  input  logic       MEM_ACK,
  output logic       WRITE_MEM,
  output logic [3:0] ROW_ADDR,
  output logic [3:0] CORE_STALL,
  output logic       BUSY,
  output logic       WB_DONE,
  output logic       WB_ERR
);
  localparam logic [1:0] LAST_IDX = 2'(NUM_ROWS - 1);

  wb_state_t  state, next_state;
  logic [3:0] memwr;
  logic [3:0] seen, seen_next;
  logic [1:0] idx, idx_next;
  logic       err_set;
  logic       tmr_expired;

  assign memwr = {MEMWR_4, MEMWR_3, MEMWR_2, MEMWR_1};

  wb_ack_timer #(.LIMIT(ACK_TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state != WRITE) || MEM_ACK),
    .enable  (state == WRITE),
    .expired (tmr_expired)
  );

  always_comb begin
    next_state = state;
    seen_next  = seen;
    idx_next   = idx;
    err_set    = 1'b0;
    case (state)
      COLLECT: begin
        seen_next = seen | memwr;
        if (&(seen | memwr)) begin
          next_state = WRITE;
          idx_next   = '0;
        end
      end
      WRITE: begin
        if (MEM_ACK) begin
          if (idx == LAST_IDX) next_state = DONE;
          else                 idx_next   = idx + 2'd1;
        end else if (tmr_expired) begin
          err_set    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        seen_next  = '0;
        idx_next   = '0;
        next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      seen       <= '0;
      idx        <= '0;
      WRITE_MEM  <= 1'b0;
      ROW_ADDR   <= '0;
      CORE_STALL <= '0;
      BUSY       <= 1'b0;
      WB_DONE    <= 1'b0;
      WB_ERR     <= 1'b0;
    end else begin
      state      <= next_state;
      seen       <= seen_next;
      idx        <= idx_next;
      WRITE_MEM  <= (next_state == WRITE);
      ROW_ADDR   <= (next_state == WRITE) ? ROW_BASE + {2'b00, idx_next} : '0;
      CORE_STALL <= (next_state == COLLECT) ? seen_next : '1;
      BUSY       <= (next_state != COLLECT);
      WB_DONE    <= (next_state == DONE);
      WB_ERR     <= WB_ERR | err_set;
    end
  end
endmodule
